decode_cycle: RTL and testbench

- Instruction-decode pipeline stage; sits directly upstream of execute_cycle and drives all of its E-stage inputs through the ID/EX pipeline register.
- Contains the 32x32 register file with writeback port, main/ALU decoder, immediate extender, and the ID/EX register with flush.
- Also exports source register indices RS1_E/RS2_E to the hazard unit for ForwardA_E/ForwardB_E generation.

---
 rtl/decode_cycle.sv | 207 ++++++++++++++++++++
 tb/tb_decode_cycle.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// Decode stage: register file with writeback port, main/ALU decoders,
// immediate extender and the flushable ID/EX pipeline register.
module decode_cycle #(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic        ALUSrcE,
    output logic        MemWriteE,
    output logic        ResultSrcE,
    output logic        BranchE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1_E,
    output logic [31:0] RD2_E,
    output logic [31:0] Imm_Ext_E,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  RD_E,
    output logic [4:0]  RS1_E,
    output logic [4:0]  RS2_E
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10
    } imm_src_t;

    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;

    assign op       = InstrD[6:0];
    assign rd       = InstrD[11:7];
    assign funct3   = InstrD[14:12];
    assign rs1      = InstrD[19:15];
    assign rs2      = InstrD[24:20];
    assign funct7_5 = InstrD[30];

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWriteW && RDW != 5'd0) begin
            regs[RDW] <= ResultW;
        end
    end

    logic        wb_hit1;
    logic        wb_hit2;
    logic [31:0] rd1;
    logic [31:0] rd2;

    assign wb_hit1 = WB_BYPASS && RegWriteW && RDW != 5'd0 && RDW == rs1;
    assign wb_hit2 = WB_BYPASS && RegWriteW && RDW != 5'd0 && RDW == rs2;

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0) rd1 = wb_hit1 ? ResultW : regs[rs1];
        if (rs2 != 5'd0) rd2 = wb_hit2 ? ResultW : regs[rs2];
    end

    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    imm_src_t   imm_src;
    logic [1:0] alu_op;

    always_comb begin
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        result_src = 1'b0;
        branch     = 1'b0;
        imm_src    = IMM_I;
        alu_op     = 2'b00;
        unique case (1'b1)
            (op == OP_LW): begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = 1'b1;
            end
            (op == OP_SW): begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
                imm_src   = IMM_S;
            end
            (op == OP_R): begin
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            (op == OP_I): begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = 2'b10;
            end
            (op == OP_BEQ): begin
                branch  = 1'b1;
                imm_src = IMM_B;
                alu_op  = 2'b01;
            end
            default: ;
        endcase
    end

    logic [2:0] alu_ctl;

    always_comb begin
        alu_ctl = 3'b000;
        unique case (alu_op)
            2'b01: alu_ctl = 3'b001;
            2'b10: begin
                unique case (funct3)
                    3'b000:  alu_ctl = (op[5] & funct7_5) ? 3'b001 : 3'b000;
                    3'b010:  alu_ctl = 3'b101;
                    3'b110:  alu_ctl = 3'b011;
                    3'b111:  alu_ctl = 3'b010;
                    default: alu_ctl = 3'b000;
                endcase
            end
            default: alu_ctl = 3'b000;
        endcase
    end

    logic [31:0] imm_ext;

    always_comb begin
        imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
        unique case (imm_src)
            IMM_S: imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B: imm_ext = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                              InstrD[30:25], InstrD[11:8], 1'b0};
            default: ;
        endcase
    end

    // Flush only kills control and register ids; data is left to load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            MemWriteE   <= 1'b0;
            ResultSrcE  <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= '0;
            RD1_E       <= '0;
            RD2_E       <= '0;
            Imm_Ext_E   <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            RD_E        <= '0;
            RS1_E       <= '0;
            RS2_E       <= '0;
        end else begin
            RD1_E     <= rd1;
            RD2_E     <= rd2;
            Imm_Ext_E <= imm_ext;
            PCE       <= PCD;
            PCPlus4E  <= PCPlus4D;
            if (FlushE) begin
                RegWriteE   <= 1'b0;
                ALUSrcE     <= 1'b0;
                MemWriteE   <= 1'b0;
                ResultSrcE  <= 1'b0;
                BranchE     <= 1'b0;
                ALUControlE <= '0;
                RD_E        <= '0;
                RS1_E       <= '0;
                RS2_E       <= '0;
            end else begin
                RegWriteE   <= reg_write;
                ALUSrcE     <= alu_src;
                MemWriteE   <= mem_write;
                ResultSrcE  <= result_src;
                BranchE     <= branch;
                ALUControlE <= alu_ctl;
                RD_E        <= rd;
                RS1_E       <= rs1;
                RS2_E       <= rs2;
            end
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: one instance with write-through
// bypass, one without, both checked against a behavioural model.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        FlushE;

    logic        rw[2];
    logic        asrc[2];
    logic        mw[2];
    logic        rsrc[2];
    logic        br[2];
    logic [2:0]  aluc[2];
    logic [31:0] rd1[2];
    logic [31:0] rd2[2];
    logic [31:0] imm[2];
    logic [31:0] pce[2];
    logic [31:0] pc4e[2];
    logic [4:0]  rde[2];
    logic [4:0]  rs1e[2];
    logic [4:0]  rs2e[2];

    always #5 clk = ~clk;

    decode_cycle #(.WB_BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .RegWriteW(RegWriteW), .RDW(RDW),
        .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(rw[0]), .ALUSrcE(asrc[0]), .MemWriteE(mw[0]),
        .ResultSrcE(rsrc[0]), .BranchE(br[0]), .ALUControlE(aluc[0]),
        .RD1_E(rd1[0]), .RD2_E(rd2[0]), .Imm_Ext_E(imm[0]),
        .PCE(pce[0]), .PCPlus4E(pc4e[0]), .RD_E(rde[0]),
        .RS1_E(rs1e[0]), .RS2_E(rs2e[0])
    );

    decode_cycle #(.WB_BYPASS(1'b0)) dut_nobyp (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .RegWriteW(RegWriteW), .RDW(RDW),
        .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(rw[1]), .ALUSrcE(asrc[1]), .MemWriteE(mw[1]),
        .ResultSrcE(rsrc[1]), .BranchE(br[1]), .ALUControlE(aluc[1]),
        .RD1_E(rd1[1]), .RD2_E(rd2[1]), .Imm_Ext_E(imm[1]),
        .PCE(pce[1]), .PCPlus4E(pc4e[1]), .RD_E(rde[1]),
        .RS1_E(rs1e[1]), .RS2_E(rs2e[1])
    );

    typedef struct {
        logic [4:0]  ctl;
        logic [2:0]  alu;
        logic [31:0] rd1_byp;
        logic [31:0] rd1_old;
        logic [31:0] rd2_byp;
        logic [31:0] rd2_old;
        logic [31:0] imm;
        bit          imm_care;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          flush;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mregs[32];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string n, input logic [191:0] act,
                       input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    function automatic logic [2:0] arith_op(input logic [2:0] f3,
                                            input bit is_sub);
        case (f3)
            3'd0:    return is_sub ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] rf(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mregs[a];
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic we,
                                   input logic [4:0] rdw,
                                   input logic [31:0] res, input logic fl,
                                   input logic [31:0] pc);
        exp_t e;
        logic signed [11:0] s12;
        logic signed [12:0] s13;
        int iv;
        logic [4:0] a1, a2;
        a1 = ins[19:15];
        a2 = ins[24:20];
        e.ctl = '0;
        e.alu = '0;
        e.imm = '0;
        e.imm_care = 0;
        case (ins[6:0])
            7'h03: begin
                e.ctl = 5'b11010;
                s12 = ins[31:20];
                iv = s12;
                e.imm = iv;
                e.imm_care = 1;
            end
            7'h23: begin
                e.ctl = 5'b01100;
                s12 = {ins[31:25], ins[11:7]};
                iv = s12;
                e.imm = iv;
                e.imm_care = 1;
            end
            7'h33: begin
                e.ctl = 5'b10000;
                e.alu = arith_op(ins[14:12], ins[30]);
            end
            7'h13: begin
                e.ctl = 5'b11000;
                e.alu = arith_op(ins[14:12], 1'b0);
                s12 = ins[31:20];
                iv = s12;
                e.imm = iv;
                e.imm_care = 1;
            end
            7'h63: begin
                e.ctl = 5'b00001;
                e.alu = 3'b001;
                s13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                iv = s13;
                e.imm = iv;
                e.imm_care = 1;
            end
            default: ;
        endcase
        e.rd1_old = rf(a1);
        e.rd2_old = rf(a2);
        e.rd1_byp = (we && rdw != 0 && rdw == a1) ? res : e.rd1_old;
        e.rd2_byp = (we && rdw != 0 && rdw == a2) ? res : e.rd2_old;
        e.pc = pc;
        e.pc4 = pc + 32'd4;
        e.rd = ins[11:7];
        e.rs1 = a1;
        e.rs2 = a2;
        e.flush = fl;
        if (fl) begin
            e.ctl = '0;
            e.alu = '0;
            e.rd = '0;
            e.rs1 = '0;
            e.rs2 = '0;
        end
        return e;
    endfunction

    task automatic check_dut(input int d, input exp_t e);
        string p;
        p = (d == 0) ? "byp" : "nobyp";
        chk({p, " ctl"}, 192'({rw[d], asrc[d], mw[d], rsrc[d], br[d]}),
            192'(e.ctl));
        chk({p, " aluctl"}, 192'(aluc[d]), 192'(e.alu));
        chk({p, " rd"}, 192'(rde[d]), 192'(e.rd));
        chk({p, " rs1"}, 192'(rs1e[d]), 192'(e.rs1));
        chk({p, " rs2"}, 192'(rs2e[d]), 192'(e.rs2));
        if (!e.flush) begin
            chk({p, " rd1"}, 192'(rd1[d]),
                192'(d == 0 ? e.rd1_byp : e.rd1_old));
            chk({p, " rd2"}, 192'(rd2[d]),
                192'(d == 0 ? e.rd2_byp : e.rd2_old));
            chk({p, " pc"}, 192'(pce[d]), 192'(e.pc));
            chk({p, " pc4"}, 192'(pc4e[d]), 192'(e.pc4));
            if (e.imm_care) chk({p, " imm"}, 192'(imm[d]), 192'(e.imm));
        end
    endtask

    task automatic check_zero(input string n);
        for (int d = 0; d < 2; d++) begin
            chk(n, 192'({rw[d], asrc[d], mw[d], rsrc[d], br[d], aluc[d],
                         rd1[d], rd2[d], imm[d], pce[d], pc4e[d],
                         rde[d], rs1e[d], rs2e[d]}), 192'd0);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic we,
                         input logic [4:0] rdw, input logic [31:0] res,
                         input logic fl);
        exp_t e;
        @(negedge clk);
        InstrD = ins;
        RegWriteW = we;
        RDW = rdw;
        ResultW = res;
        FlushE = fl;
        PCD = $urandom;
        PCPlus4D = PCD + 32'd4;
        e = model(ins, we, rdw, res, fl, PCD);
        sb.push_back(e);
        if (we && rdw != 0) mregs[rdw] = res;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        RegWriteW = 1'b0;
        rst = 1'b0;
        #1;
        check_zero("mid_reset");
        clear_model();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr(input logic [4:0] rdw);
        logic [6:0] op, f7;
        logic [4:0] a1, a2, d;
        logic [2:0] f3;
        a1 = ($urandom_range(0, 2) == 0) ? rdw : 5'($urandom);
        a2 = ($urandom_range(0, 2) == 0) ? rdw : 5'($urandom);
        d = 5'($urandom);
        f3 = 3'($urandom);
        f7 = $urandom_range(0, 1) ? 7'h20 : 7'($urandom);
        case ($urandom_range(0, 5))
            0: op = 7'h03;
            1: op = 7'h23;
            2: op = 7'h33;
            3: op = 7'h13;
            4: op = 7'h63;
            default: op = 7'($urandom);
        endcase
        return {f7, a2, a1, f3, d, op};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check_dut(0, e);
                check_dut(1, e);
            end
        end
    end

    initial begin
        logic [4:0] w;
        clear_model();
        rst = 1'b0;
        FlushE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            InstrD = $urandom;
            PCD = $urandom;
            PCPlus4D = $urandom;
            RegWriteW = 1'($urandom);
            RDW = 5'($urandom);
            ResultW = $urandom;
            FlushE = 1'($urandom);
        end
        @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        RegWriteW = 1'b0;
        FlushE = 1'b0;
        rst = 1'b1;

        issue(32'h0000_0013, 1'b0, 5'd0, 32'd0, 1'b0);
        issue(32'h0000_0013, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
        issue(32'h0052_8333, 1'b0, 5'd0, 32'd0, 1'b0);
        issue(32'h0000_0013, 1'b1, 5'd7, 32'hAAAA_5555, 1'b0);
        issue(32'h4003_80B3, 1'b1, 5'd7, 32'h1234_5678, 1'b0);
        issue(32'hFFC0_A103, 1'b0, 5'd0, 32'd0, 1'b0);
        issue(32'h0020_A423, 1'b0, 5'd0, 32'd0, 1'b0);
        issue(32'hFE00_0CE3, 1'b0, 5'd0, 32'd0, 1'b0);
        issue(32'hFFC0_A103, 1'b1, 5'd3, 32'h0000_0055, 1'b1);
        issue(32'h0001_8233, 1'b0, 5'd0, 32'd0, 1'b0);
        issue(32'h0000_0013, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        issue(32'h0000_00B3, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        issue(32'h0000_007F, 1'b0, 5'd0, 32'd0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) mid_reset();
            w = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            issue(rand_instr(w), 1'($urandom), w, $urandom,
                  $urandom_range(0, 7) == 0);
        end

        @(negedge clk);
        FlushE = 1'b0;
        RegWriteW = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
